// File: rtl/memory_stage_pipe_if.sv
// rtl/memory_stage_pipe_if.sv - EX->MEM and MEM->WB handshake bundle for the MEM stage
interface memory_stage_pipe_if #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4
);
  logic              validM;
  logic              readyM;
  logic              MemReadM;
  logic              MemWriteM;
  logic              RegWriteM;
  logic [REG_W-1:0]  destRegM;
  logic [DATA_W-1:0] alu_resultM;
  logic [DATA_W-1:0] write_dataM;
  logic              validW;
  logic              readyW;
  logic              RegWriteW;
  logic              MemToRegW;
  logic [REG_W-1:0]  destRegW;
  logic [DATA_W-1:0] alu_resultW;
  logic [DATA_W-1:0] MemReadDataW;

  modport master (
    output validM, MemReadM, MemWriteM, RegWriteM, destRegM, alu_resultM, write_dataM, readyW,
    input  readyM, validW, RegWriteW, MemToRegW, destRegW, alu_resultW, MemReadDataW
  );

  modport slave (
    input  validM, MemReadM, MemWriteM, RegWriteM, destRegM, alu_resultM, write_dataM, readyW,
    output readyM, validW, RegWriteW, MemToRegW, destRegW, alu_resultW, MemReadDataW
  );
endinterface

// File: rtl/memory_stage_pipe.sv
// rtl/memory_stage_pipe.sv - MEM stage: data memory, load/store, MEM/WB register with stalling
module memory_stage_pipe #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 8,
  parameter int REG_W    = 4,
  parameter int READ_LAT = 1
) (
  input logic                clk,
  input logic                reset,
  memory_stage_pipe_if.slave bus
);
  typedef enum logic {IDLE, WAIT} state_t;

  localparam bit       MULTI    = (READ_LAT > 1);
  localparam logic [2:0] CNT_LAST = 3'(READ_LAT > 1 ? READ_LAT - 2 : 0);

  state_t            state;
  state_t            state_next;
  logic [2:0]        cnt;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [REG_W-1:0]  pend_dest;
  logic [DATA_W-1:0] pend_alu;
  logic              pend_rw;

  logic              slot_free;
  logic              accept;
  logic              is_store;
  logic              is_load;
  logic              wait_done;
  logic [ADDR_W-1:0] addr_m;
  logic [ADDR_W-1:0] addr_p;

  assign slot_free  = !bus.validW || bus.readyW;
  assign bus.readyM = (state == IDLE) && slot_free;
  assign accept     = bus.validM && bus.readyM;
  assign is_store   = bus.MemWriteM;
  assign is_load    = bus.MemReadM && !bus.MemWriteM;
  assign addr_m     = bus.alu_resultM[ADDR_W-1:0];
  assign addr_p     = pend_alu[ADDR_W-1:0];
  assign wait_done  = (state == WAIT) && (cnt == CNT_LAST) && slot_free;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (accept)
        cnt <= '0;
      else if (state == WAIT && cnt != CNT_LAST)
        cnt <= cnt + 3'd1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept && is_load && MULTI) state_next = WAIT;
      WAIT: if (wait_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Multi-cycle loads park their W-side fields here while the read completes.
  always_ff @(posedge clk) begin
    if (accept && is_load) begin
      pend_dest <= bus.destRegM;
      pend_alu  <= bus.alu_resultM;
      pend_rw   <= bus.RegWriteM;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && is_store)
      mem[addr_m] <= bus.write_dataM;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.validW       <= 1'b0;
      bus.RegWriteW    <= 1'b0;
      bus.MemToRegW    <= 1'b0;
      bus.destRegW     <= '0;
      bus.alu_resultW  <= '0;
      bus.MemReadDataW <= '0;
    end else if (accept && !(is_load && MULTI)) begin
      bus.validW       <= 1'b1;
      bus.RegWriteW    <= bus.RegWriteM && !bus.MemWriteM;
      bus.MemToRegW    <= is_load;
      bus.destRegW     <= bus.destRegM;
      bus.alu_resultW  <= bus.alu_resultM;
      bus.MemReadDataW <= is_load ? mem[addr_m] : '0;
    end else if (wait_done) begin
      bus.validW       <= 1'b1;
      bus.RegWriteW    <= pend_rw;
      bus.MemToRegW    <= 1'b1;
      bus.destRegW     <= pend_dest;
      bus.alu_resultW  <= pend_alu;
      bus.MemReadDataW <= mem[addr_p];
    end else if (bus.readyW) begin
      bus.validW <= 1'b0;
    end
  end
endmodule
